aeolus_sequencer: RTL
=====================

Name: aeolus_sequencer

Overview:
- Fetch/execute controller for the Aeolus 4-bit CPU.
- Owns the program counter and drives the combinational program ROM address.
- Latches the returned 4-bit opcode and issues one-cycle load/ALU/shift strobes to the datapath.
- Implements the conditional-skip instructions (SNZA/SNZS) from datapath zero flags.

Parameters:
- PC_WIDTH, 4, program counter / ROM address width.
- OP_WIDTH, 4, opcode width.
- HALT_ON_WRAP, 0, if 1 return to IDLE instead of wrapping PC from max to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; start/continue execution.
- rom_addr  out  PC_WIDTH  ROM address (= pc).
- rom_data  in  OP_WIDTH  opcode from ROM, valid same cycle as rom_addr.
- zero_a  in  1  datapath flag: register A == 0.
- zero_s  in  1  datapath flag: shift register == 0.
- ld_a, ld_b, ld_o  out  1 each  register load strobes.
- ld_s  out  1  shift-register load strobe.
- ld_s_sel  out  1  shift load source: 0 = A, 1 = B.
- alu_op  out  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A.
- alu_ld  out  1  ALU result write to accumulator.
- shl, shr  out  1 each  shift strobes.
- clr  out  1  clear strobe.
- busy  out  1  high when not in IDLE.
- pc  out  PC_WIDTH  current program counter.

Behaviour:
- Opcode map: 0 LDA, 1 LDB, 2 LDO, 3 LDSA, 4 LDSB, 5 LSH, 6 RSH, 7 CLR, 8 SNZA, 9 SNZS, A ADD, B SUB, C AND, D OR, E XOR, F NOT.
- States:
  - IDLE: leave when run = 1, go to FETCH.
  - FETCH: ir <= rom_data, go to EXEC.
  - EXEC: strobes asserted, PC updated. Go to FETCH if run = 1, else IDLE.
- Each instruction takes 2 cycles. Strobes are combinational from ir and high only in EXEC, one cycle, and at most one strobe group per instruction.
- Strobe decode:
  - LDA/LDB/LDO -> ld_a/ld_b/ld_o.
  - LDSA/LDSB -> ld_s with ld_s_sel 0/1.
  - LSH -> shl. RSH -> shr. CLR -> clr.
  - A–F -> alu_ld with alu_op 0–5.
  - SNZA/SNZS -> no strobe.
- PC update in EXEC:
  - Default pc+1, modulo 2^PC_WIDTH.
  - SNZA with zero_a = 0, or SNZS with zero_s = 0: pc+2 (skip next). Flag sampled in the EXEC cycle.
  - Skip at pc 14 gives 0; skip at pc 15 gives 1.
- HALT_ON_WRAP = 1: if the next pc would be less than or equal to the current pc (wrap), load pc = 0 and go to IDLE regardless of run.
- run deasserted mid-instruction: the current EXEC completes, then IDLE. pc holds, so execution resumes there.
- Reset (async): pc = 0, ir = 7 (CLR), state IDLE, all strobes 0, busy 0.
- Reset mid-instruction: strobes drop immediately; no partial update survives.
- rom_addr = pc at all times. busy = (state != IDLE).

Optional Feature:
- Macro AEOLUS_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and input port step_mode (1 bit).
  - When step_mode = 1, EXEC leaves to a WAIT state instead of FETCH.
  - WAIT advances to FETCH on a step rising edge (edge detected internally, registered). It goes to IDLE if run = 0.
  - Exactly one instruction executes per step pulse.
- Undefined: ports absent, no WAIT state, behaviour as above.

Decomposition:
- aeolus_pkg:
  - Opcode localparams (OP_LDA … OP_NOT).
  - ALU_ADD … ALU_NOT codes.
  - State encoding (S_IDLE, S_FETCH, S_EXEC, S_WAIT).
- Sub-module aeolus_decoder: purely combinational. Takes ir and an exec enable; produces the strobes, alu_op and the is_skip / skip_src flags.
- Sequencer keeps the FSM, pc and ir.

Test Plan:
- Reset, then run = 1 with ROM {0,1,A,2}: ld_a high at cycle 2, ld_b at 4, alu_ld with alu_op = 0 at 6, ld_o at 8; pc = 4 after cycle 8.
- SNZA at pc 6 with zero_a = 0: next fetch at pc 8, no strobe for pc 7. Repeat with zero_a = 1: pc 7 executes (ld_o).
- SNZS at pc 15 with zero_s = 0: pc wraps to 1. With HALT_ON_WRAP = 1: pc = 0, state IDLE, busy 0.
- run dropped during FETCH of pc 3: that instruction's strobe still fires, then IDLE with pc = 4. Re-asserting run resumes at pc 4.
- rst_n asserted during EXEC of ADD: alu_ld drops combinationally within the cycle; pc = 0, busy = 0 after release.
- AEOLUS_SINGLE_STEP_EN, step_mode = 1: three step pulses give exactly three EXEC cycles and pc = 3; holding step high does not repeat.

Source files
------------

// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus 4-bit CPU sequencer: opcode map,
// ALU operation codes and the controller state encoding.
package aeolus_pkg;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_LDB  = 4'h1;
  localparam logic [3:0] OP_LDO  = 4'h2;
  localparam logic [3:0] OP_LDSA = 4'h3;
  localparam logic [3:0] OP_LDSB = 4'h4;
  localparam logic [3:0] OP_LSH  = 4'h5;
  localparam logic [3:0] OP_RSH  = 4'h6;
  localparam logic [3:0] OP_CLR  = 4'h7;
  localparam logic [3:0] OP_SNZA = 4'h8;
  localparam logic [3:0] OP_SNZS = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/aeolus_decoder.sv
// Combinational instruction decoder: turns the latched opcode into one-cycle
// datapath strobes while exec_en is high, and flags the conditional skips.
module aeolus_decoder
  import aeolus_pkg::*;
(
  input  logic [3:0] ir,
  input  logic       exec_en,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_o,
  output logic       ld_s,
  output logic       ld_s_sel,
  output logic [2:0] alu_op,
  output logic       alu_ld,
  output logic       shl,
  output logic       shr,
  output logic       clr,
  output logic       is_skip,
  output logic       skip_src   // 0 = zero_a, 1 = zero_s
);

  // Opcode decode; every output idles low outside EXEC
  always_comb begin
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_o     = 1'b0;
    ld_s     = 1'b0;
    ld_s_sel = 1'b0;
    alu_op   = ALU_ADD;
    alu_ld   = 1'b0;
    shl      = 1'b0;
    shr      = 1'b0;
    clr      = 1'b0;
    is_skip  = 1'b0;
    skip_src = 1'b0;
    if (exec_en) begin
      case (ir)
        OP_LDA:  ld_a = 1'b1;
        OP_LDB:  ld_b = 1'b1;
        OP_LDO:  ld_o = 1'b1;
        OP_LDSA: ld_s = 1'b1;
        OP_LDSB: begin ld_s = 1'b1; ld_s_sel = 1'b1; end
        OP_LSH:  shl = 1'b1;
        OP_RSH:  shr = 1'b1;
        OP_CLR:  clr = 1'b1;
        OP_SNZA: is_skip = 1'b1;
        OP_SNZS: begin is_skip = 1'b1; skip_src = 1'b1; end
        OP_ADD:  begin alu_ld = 1'b1; alu_op = ALU_ADD; end
        OP_SUB:  begin alu_ld = 1'b1; alu_op = ALU_SUB; end
        OP_AND:  begin alu_ld = 1'b1; alu_op = ALU_AND; end
        OP_OR:   begin alu_ld = 1'b1; alu_op = ALU_OR;  end
        OP_XOR:  begin alu_ld = 1'b1; alu_op = ALU_XOR; end
        OP_NOT:  begin alu_ld = 1'b1; alu_op = ALU_NOT; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aeolus_sequencer.sv
// Fetch/execute controller for the Aeolus 4-bit CPU: owns pc and ir, runs the
// IDLE/FETCH/EXEC state machine and resolves SNZA/SNZS skips.
// Optional single-step mode is compiled in with AEOLUS_SINGLE_STEP_EN.
module aeolus_sequencer
  import aeolus_pkg::*;
#(
  parameter int PC_WIDTH     = 4,
  parameter int OP_WIDTH     = 4,
  parameter int HALT_ON_WRAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
`ifdef AEOLUS_SINGLE_STEP_EN
  input  logic                step,
  input  logic                step_mode,
`endif
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [OP_WIDTH-1:0] rom_data,
  input  logic                zero_a,
  input  logic                zero_s,
  output logic                ld_a,
  output logic                ld_b,
  output logic                ld_o,
  output logic                ld_s,
  output logic                ld_s_sel,
  output logic [2:0]          alu_op,
  output logic                alu_ld,
  output logic                shl,
  output logic                shr,
  output logic                clr,
  output logic                busy,
  output logic [PC_WIDTH-1:0] pc
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [OP_WIDTH-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_step;
  logic                is_skip, skip_src, skip_taken;
  logic                go_wait;

`ifdef AEOLUS_SINGLE_STEP_EN
  logic step_q, step_d, step_prev_q, step_prev_d;
  logic step_rise;

  // Step input sampled, then compared with its previous sample for a rising edge
  always_comb begin
    step_d      = step;
    step_prev_d = step_q;
  end

  // Step edge-detector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign step_rise = step_q & ~step_prev_q;
  assign go_wait   = step_mode;
`else
  assign go_wait   = 1'b0;
`endif

  aeolus_decoder u_dec (
    .ir       (ir_q[3:0]),
    .exec_en  (state_q == S_EXEC),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_o     (ld_o),
    .ld_s     (ld_s),
    .ld_s_sel (ld_s_sel),
    .alu_op   (alu_op),
    .alu_ld   (alu_ld),
    .shl      (shl),
    .shr      (shr),
    .clr      (clr),
    .is_skip  (is_skip),
    .skip_src (skip_src)
  );

  // Skip is taken when the selected flag reports non-zero in the EXEC cycle
  assign skip_taken = is_skip & ~(skip_src ? zero_s : zero_a);
  assign pc_step    = pc_q + (skip_taken ? PC_WIDTH'(2) : PC_WIDTH'(1));

  // Next-state, pc and ir computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        // In single-step mode the first instruction also waits for a pulse
        if (run) state_d = go_wait ? S_WAIT : S_FETCH;
      end
      S_FETCH: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d = pc_step;
        if ((HALT_ON_WRAP != 0) && (pc_step <= pc_q)) begin
          pc_d    = '0;
          state_d = S_IDLE;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = go_wait ? S_WAIT : S_FETCH;
        end
      end
      S_WAIT: begin
`ifdef AEOLUS_SINGLE_STEP_EN
        if (!run)           state_d = S_IDLE;
        else if (step_rise) state_d = S_FETCH;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state, program counter and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= OP_WIDTH'(OP_CLR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign busy     = (state_q != S_IDLE);

endmodule
